// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM state type and pipeline-register bubble fields.
// Revision: 1.0
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } pctrl_state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_fields_t;

  // Control-field values a pipeline register loads when it is flushed.
  localparam ctrl_fields_t BUBBLE_CTRL = '{
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0
  };

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: load-use compare between the load in EX and the sources in ID.
// Revision: 1.0
`default_nettype none

module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int RF_ADDRESS_W = 5
) (
  input  logic [RF_ADDRESS_W-1:0] rs1_IFID,
  input  logic [RF_ADDRESS_W-1:0] rs2_IFID,
  input  logic [RF_ADDRESS_W-1:0] rd_IDEX,
  input  logic                    MemRead_IDEX,
  output logic                    load_use
);

  // x0 is hard-wired zero, so a load into it never creates a dependency.
  assign load_use = MemRead_IDEX && (rd_IDEX != '0) &&
                    ((rd_IDEX == rs1_IFID) || (rd_IDEX == rs2_IFID));

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline with memory
// timeout detection and saturating stall/flush counters. Revision: 1.0
`default_nettype none

module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RF_ADDRESS_W = 5,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [RF_ADDRESS_W-1:0] rs1_IFID,
  input  logic [RF_ADDRESS_W-1:0] rs2_IFID,
  input  logic [RF_ADDRESS_W-1:0] rd_IDEX,
  input  logic                    MemRead_IDEX,
  input  logic                    branch_taken_EX,
  input  logic                    mem_req_EXMEM,
  input  logic                    mem_ready,
  output logic                    en_PC,
  output logic                    en_IFID,
  output logic                    en_IDEX,
  output logic                    en_EXMEM,
  output logic                    en_MEMWB,
  output logic                    flush_IFID,
  output logic                    flush_IDEX,
  output logic                    flush_MEMWB,
  output logic                    mem_err,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  pctrl_state_t      state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              mem_stall;
  logic              do_flush;
  logic              do_lu_stall;

  hazard_detect #(
    .RF_ADDRESS_W (RF_ADDRESS_W)
  ) u_hazard_detect (
    .rs1_IFID     (rs1_IFID),
    .rs2_IFID     (rs2_IFID),
    .rd_IDEX      (rd_IDEX),
    .MemRead_IDEX (MemRead_IDEX),
    .load_use     (load_use)
  );

  always_comb begin
    mem_stall = 1'b0;
    case (state)
      RUN:      mem_stall = mem_req_EXMEM && !mem_ready;
      MEM_WAIT: mem_stall = !mem_ready;
      default:  mem_stall = 1'b0;
    endcase
  end

  // A flushed branch squashes the ID instruction, so its load-use is moot.
  assign do_flush    = (state != ERR) && !mem_stall && branch_taken_EX;
  assign do_lu_stall = (state != ERR) && !mem_stall && !branch_taken_EX && load_use;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_next;
      if (mem_stall) wait_cnt <= wait_cnt + 1'b1;
      else           wait_cnt <= '0;
      if (state_next == ERR) mem_err <= 1'b1;
      if ((mem_stall || do_lu_stall) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (do_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    if (state != ERR) begin
      if (mem_stall) state_next = (wait_cnt == WAIT_LAST) ? ERR : MEM_WAIT;
      else           state_next = RUN;
    end
  end

  always_comb begin
    en_PC       = 1'b1;
    en_IFID     = 1'b1;
    en_IDEX     = 1'b1;
    en_EXMEM    = 1'b1;
    en_MEMWB    = 1'b1;
    flush_IFID  = 1'b0;
    flush_IDEX  = 1'b0;
    flush_MEMWB = 1'b0;
    if (reset) begin
      {en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB} = 5'b00000;
      {flush_IFID, flush_IDEX, flush_MEMWB}         = 3'b111;
    end else if (state == ERR) begin
      {en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB} = 5'b00000;
    end else if (mem_stall) begin
      {en_PC, en_IFID, en_IDEX, en_EXMEM} = 4'b0000;
      flush_MEMWB = 1'b1;
    end else if (do_flush) begin
      flush_IFID = 1'b1;
      flush_IDEX = 1'b1;
    end else if (do_lu_stall) begin
      en_PC      = 1'b0;
      en_IFID    = 1'b0;
      flush_IDEX = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives load enables and bubble-insert (flush) strobes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves three hazard sources in priority order: data-memory wait, taken branch/jump, load-use. It also keeps saturating performance counters and a sticky memory-timeout error.

## Interface
Parameters:
- RF_ADDRESS_W, 5, register-file address width
- MEM_TIMEOUT, 15, max consecutive wait cycles before error (≥1)
- CNT_W, 16, width of performance counters

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- rs1_IFID, rs2_IFID  in  RF_ADDRESS_W  source registers of instruction in ID
- rd_IDEX  in  RF_ADDRESS_W  destination of instruction in EX
- MemRead_IDEX  in  1  instruction in EX is a load
- branch_taken_EX  in  1  branch/jump resolved taken in EX
- mem_req_EXMEM  in  1  instruction in MEM accesses data memory
- mem_ready  in  1  data memory completes access this cycle
- en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB  out  1 each  register load enables (1 = capture)
- flush_IFID, flush_IDEX, flush_MEMWB  out  1 each  on the next edge, load a bubble (RegWrite/MemRead/MemWrite/MemtoReg = 0)
- mem_err  out  1  sticky memory-timeout error
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- FSM states: RUN, MEM_WAIT, ERR. Outputs are Mealy: a combinational function of state and inputs.
- Priority: MEM_WAIT/memory stall > branch flush > load-use.
- Memory stall (RUN with mem_req_EXMEM=1 and mem_ready=0, or MEM_WAIT with mem_ready=0):
  - en_PC..en_EXMEM = 0.
  - en_MEMWB = 1 and flush_MEMWB = 1, so WB sees a bubble.
  - Next state is MEM_WAIT.
  - Branch and load-use are ignored; they re-evaluate after release because the upstream stages are held.
- MEM_WAIT with mem_ready=1: release in the same cycle (all enables 1), next state RUN, and the lower-priority rules apply in that cycle.
- Taken branch (no memory stall, branch_taken_EX=1): all enables 1, flush_IFID = flush_IDEX = 1. flush_cnt increments by 1.
- Load-use (no memory stall, no branch):
  - Condition: MemRead_IDEX=1 and rd_IDEX≠0 and (rd_IDEX==rs1_IFID or rd_IDEX==rs2_IFID).
  - Response: en_PC = en_IFID = 0, flush_IDEX = 1, en_IDEX..en_MEMWB = 1.
  - Exactly one bubble per occurrence, because the load advances to MEM.
- Default RUN: all enables 1, all flushes 0.
- Timeout and ERR:
  - wait_cnt counts consecutive memory-stall cycles and clears on release.
  - When a stall cycle occurs with wait_cnt == MEM_TIMEOUT−1, the next state is ERR.
  - ERR: all enables 0, all flushes 0, mem_err = 1. ERR is exited only by reset.
- stall_cnt increments on every memory-stall or load-use cycle. Both counters saturate at 2^CNT_W−1.

## Timing
- Reset asserted (asynchronous): state = RUN, wait_cnt = 0, stall_cnt = flush_cnt = mem_err = 0.
- While reset is high, all en_* = 0 and flush_IFID = flush_IDEX = flush_MEMWB = 1, overriding the FSM.
- Reset asserted mid-MEM_WAIT or in ERR: return to RUN immediately and clear all state.
- Input-to-enable path is combinational, with zero cycles of latency. State, wait_cnt and counters update on the edge.
- Load-use costs exactly 1 cycle. A taken branch costs 2 squashed instructions with no stall cycle.
- Memory access that is ready in its first MEM cycle: no stall. Each additional cycle costs 1 stall.
- Simultaneous branch_taken_EX and memory stall: no flush that cycle; the flush occurs in the release cycle, counted once.
- Simultaneous branch and load-use: flush only. The load-use instruction is on the wrong path; no stall, no stall_cnt increment.
- rd_IDEX = 0 never stalls.

## Structure
- Package pipe_ctrl_pkg holds:
  - typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} pctrl_state_t
  - bubble control-field constants shared with the pipeline registers
- Sub-module hazard_detect: purely combinational load-use compare, producing a load_use output. Everything else stays in pipeline_ctrl.
- Counters are plain saturating registers; no separate module.

## Test plan
- Load-use: MemRead_IDEX=1, rd_IDEX=5, rs2_IFID=5 for one cycle → en_PC = en_IFID = 0, flush_IDEX = 1 for exactly 1 cycle; stall_cnt = 1. Repeat with rd_IDEX=0 → no stall.
- Branch: branch_taken_EX=1 for one cycle → flush_IFID = flush_IDEX = 1, all enables 1; flush_cnt = 1. Assert simultaneously with load-use → flush only, stall_cnt unchanged.
- Memory wait:
  - Stimulus: mem_req_EXMEM=1, mem_ready held 0 for 3 cycles then 1.
  - Response: 3 cycles with en_EXMEM = 0 and flush_MEMWB = 1, then release; stall_cnt = 3; state back to RUN.
- Memory wait plus branch: branch_taken_EX=1 held during a 2-cycle wait → no flush during the wait; single flush in the release cycle; flush_cnt = 1.
- Timeout: mem_ready held 0 with MEM_TIMEOUT=4 → mem_err = 1 after 4 stall cycles; enables stay 0; reset pulse mid-ERR → RUN, counters 0.
- Saturation: CNT_W=2, 5 load-use events → stall_cnt = 3.
